// File: rtl/mult_arbiter_pkg.sv
// Shared types for the two-requester shared-multiplier arbiter.
// Holds the FSM state enum, the requester index type and the default operand width.
package mult_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic idx_t;

  function automatic logic [1:0] idx_onehot(input idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mult_arbiter_core.sv
// mult_core: sequential shift-add multiplier, one step per cycle, multiplier LSB first.
// load clears the accumulator; done rises once WIDTH steps have been applied.
module mult_core
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // The multiplicand shifts left as the multiplier shifts right, so bit i of b adds a<<i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      count  <= '0;
    end else if (step && !done) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end

  assign done    = (count == CW'(WIDTH));
  assign product = acc;

endmodule

// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of one shared sequential multiplier (FSM IDLE/RUN/DONE).
// Define MULT_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic [1:0]           ack,
  output logic [2*WIDTH-1:0]   out,
  output logic [1:0]           out_valid,
  input  logic [1:0]           out_ready,
  output logic                 busy
);

  state_t             state;
  state_t             next_state;
  idx_t               grant;
  idx_t               next_grant;
  logic               load;
  logic               step;
  logic               core_done;
  logic [2*WIDTH-1:0] product;

`ifndef MULT_ARBITER_FIXED_PRIO_EN
  idx_t               last_grant;
`endif

  // Tie-break: fixed build always favours requester 0, default build alternates.
  always_comb begin
    next_grant = 1'b0;
    unique case (req)
      2'b01:   next_grant = 1'b0;
      2'b10:   next_grant = 1'b1;
`ifdef MULT_ARBITER_FIXED_PRIO_EN
      2'b11:   next_grant = 1'b0;
`else
      2'b11:   next_grant = ~last_grant;
`endif
      default: next_grant = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req != 2'b00)    next_state = RUN;
      RUN:     if (core_done)       next_state = DONE;
      DONE:    if (out_ready[grant]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    load = (state == IDLE) && (req != 2'b00);
    step = (state == RUN);
  end

  // Handshake registers: ack pulses for one cycle, out/out_valid load as DONE is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack        <= 2'b00;
      out_valid  <= 2'b00;
      out        <= '0;
      grant      <= 1'b0;
`ifndef MULT_ARBITER_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack <= 2'b00;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            ack        <= idx_onehot(next_grant);
            grant      <= next_grant;
`ifndef MULT_ARBITER_FIXED_PRIO_EN
            last_grant <= next_grant;
`endif
          end
        end
        RUN: begin
          if (core_done) begin
            out       <= product;
            out_valid <= idx_onehot(grant);
          end
        end
        DONE: begin
          if (out_ready[grant]) begin
            out_valid <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

  mult_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .a       (next_grant ? a1 : a0),
    .b       (next_grant ? b1 : b0),
    .product (product),
    .done    (core_done)
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed scenarios plus random operations
// compared against an arithmetic model of arbitration, product and latency.
module tb_mult_arbiter;

  localparam int W = 6;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req;
  logic [W-1:0]     a0, b0, a1, b1;
  logic [1:0]       ack;
  logic [2*W-1:0]   out;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int model_last = 1;

  mult_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .ack       (ack),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh_of(input int g);
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  // Reference arbitration: lone requester wins; ties alternate (or favour 0 with fixed priority).
  function automatic int model_pick(input logic [1:0] r);
    if (r == 2'b01) return 0;
    if (r == 2'b10) return 1;
`ifdef MULT_ARBITER_FIXED_PRIO_EN
    return 0;
`else
    return (model_last == 1) ? 0 : 1;
`endif
  endfunction

  // One full transaction; starts and ends just after a falling edge.
  task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] late,
                                input logic keep_other, input int stall);
    int          g;
    logic [31:0] exp;
    logic [1:0]  oh;
    bit          got;
    req = r;
    g   = model_pick(r);
    oh  = oh_of(g);
    exp = (g == 0) ? 32'(a0) * 32'(b0) : 32'(a1) * 32'(b1);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check_output("ack_seen", 32'(got), 32'd1);
    if (!got) begin
      req = 2'b00;
      return;
    end
    check_output("ack_onehot", 32'(ack), 32'(oh));
    check_output("busy_run", 32'(busy), 32'd1);
    model_last = g;
    req = (keep_other ? (r & ~oh) : 2'b00) | late;
    out_ready = 2'b11;
    for (int n = 1; n < W + 1; n++) begin
      @(negedge clk);
      if (n == 1) check_output("ack_pulse", 32'(ack), 32'd0);
      if (n == W) check_output("valid_early", 32'(out_valid), 32'd0);
    end
    out_ready = ~oh;
    @(negedge clk);
    check_output("valid_latency", 32'(out_valid), 32'(oh));
    check_output("product", 32'(out), exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_output("stall_out", 32'(out), exp);
      check_output("stall_valid", 32'(out_valid), 32'(oh));
      check_output("stall_busy", 32'(busy), 32'd1);
      check_output("stall_ack", 32'(ack), 32'd0);
    end
    out_ready = oh;
    @(negedge clk);
    out_ready = 2'b00;
    check_output("valid_clear", 32'(out_valid), 32'd0);
    check_output("out_hold", 32'(out), exp);
    check_output("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    req = 2'b00;
    out_ready = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    check_output("rst_ack", 32'(ack), 32'd0);
    check_output("rst_out", 32'(out), 32'd0);
    check_output("rst_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    model_last = 1;

    $display("[TB] tie after reset, then the pending requester");
    a0 = 6'd5; b0 = 6'd3; a1 = 6'd1; b1 = 6'd7;
    apply_stimulus(2'b11, 2'b00, 1'b1, 1);
    apply_stimulus(2'b10, 2'b00, 1'b0, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 0);
    apply_stimulus(2'b11, 2'b00, 1'b0, 0);

    $display("[TB] single requester 2*2");
    a0 = 6'd2; b0 = 6'd2;
    apply_stimulus(2'b01, 2'b00, 1'b0, 0);

    $display("[TB] stalled consumer with competing request");
    a1 = 6'd51; b1 = 6'd11; a0 = 6'd9; b0 = 6'd9;
    apply_stimulus(2'b10, 2'b01, 1'b0, 5);
    apply_stimulus(2'b01, 2'b00, 1'b0, 0);

    $display("[TB] maximum and zero operands");
    a0 = 6'd63; b0 = 6'd63;
    apply_stimulus(2'b01, 2'b00, 1'b0, 1);
    a0 = 6'd0; b0 = 6'd45;
    apply_stimulus(2'b01, 2'b00, 1'b0, 0);

    $display("[TB] random operations");
    for (int k = 0; k < 20; k++) begin
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      apply_stimulus(2'($urandom_range(1, 3)), 2'b00,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("[TB] reset in the third RUN cycle");
    req = 2'b00;
    @(negedge clk);
    a0 = 6'd7; b0 = 6'd9;
    req = 2'b01;
    @(negedge clk);
    check_output("rr_ack", 32'(ack), 32'd1);
    req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("async_ack", 32'(ack), 32'd0);
    check_output("async_out", 32'(out), 32'd0);
    check_output("async_valid", 32'(out_valid), 32'd0);
    check_output("async_busy", 32'(busy), 32'd0);
    model_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid != 2'b00 || busy) seen = 1'b1;
    end
    check_output("no_result_after_reset", 32'(seen), 32'd0);
    a0 = 6'd4; b0 = 6'd6;
    apply_stimulus(2'b01, 2'b00, 1'b0, 0);

    $display("[TB] requester 1 withdraws during an operation");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    a0 = 6'd12; b0 = 6'd13; a1 = 6'd3; b1 = 6'd3;
    apply_stimulus(2'b11, 2'b00, 1'b0, 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack != 2'b00) seen = 1'b1;
    end
    check_output("no_ack_after_withdraw", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, default 6, operand width; result width is 2*WIDTH.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  2  per-requester request; bit i is requester i; held until ack[i].
REQ-005 a0, b0  input  WIDTH each  requester 0 unsigned operands; valid while req[0] is high.
REQ-006 a1, b1  input  WIDTH each  requester 1 unsigned operands; valid while req[1] is high.
REQ-007 ack  output  2  one-cycle pulse; operands of requester i captured.
REQ-008 out  output  2*WIDTH  product of the most recent completed operation.
REQ-009 out_valid  output  2  bit i high while out holds requester i's pending result.
REQ-010 out_ready  input  2  bit i: requester i consumes the result.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, RUN, DONE; one shared multiplier, one operation at a time.
REQ-013 IDLE, req nonzero at an edge: grant one requester, capture its operands, ack[g]=1 for the next cycle only, go to RUN with count=0.
REQ-014 Arbitration (default): round-robin; only one requesting -> grant it; both -> grant the one not granted last; after reset requester 0 wins the first tie.
REQ-015 RUN: one shift-add step per cycle, multiplier LSB first; exactly WIDTH cycles; then go to DONE.
REQ-016 Entering DONE: load out with the full 2*WIDTH-bit product and set out_valid[g]; out_valid rises exactly WIDTH+1 edges after the capture edge.
REQ-017 DONE: out and out_valid[g] hold until out_ready[g] is sampled high; then clear out_valid and go to IDLE; the next grant is possible no earlier than the following edge.
REQ-018 out_ready[i] while out_valid[i]=0 is ignored; out_ready of the non-granted requester is ignored.
REQ-019 req during RUN/DONE: no ack and no capture; arbitration happens only in IDLE.
REQ-020 req dropped before ack: the request is withdrawn, no operation, no error.
REQ-021 Zero operand: full WIDTH-cycle latency still applies; result 0.
REQ-022 Maximum operands: (2^WIDTH-1)^2 is exact; no overflow, no truncation.
REQ-023 out keeps its last value after the handshake until the next DONE entry.
REQ-024 At most one bit of ack and at most one bit of out_valid are high at any time.

Reset
REQ-025 rst_n low at any time forces state=IDLE, count=0, ack=0, out_valid=0, out=0, busy=0, round-robin pointer=requester 1 last.
REQ-026 Reset during RUN or DONE discards the operation; no result is delivered after release.
REQ-027 First grant is possible on the first edge after rst_n deasserts.

Configuration
REQ-028 Macro MULT_ARBITER_FIXED_PRIO_EN defined: fixed priority; requester 0 always wins a tie.
REQ-029 Macro undefined: round-robin per REQ-014; all other behaviour is identical in both builds.

Structure
REQ-030 Shared package holds the FSM state enum (IDLE, RUN, DONE), the requester-index type and the default WIDTH constant.
REQ-031 One sub-module, mult_core: sequential WIDTH-cycle shift-add unit with load/step/done; mult_arbiter holds the FSM, arbitration and handshakes.

Verification
REQ-032 Requester 0 only, a0=2, b0=2 -> ack[0] pulse; out=4 with out_valid[0] 7 edges after capture (WIDTH=6).
REQ-033 Both requesters assert in the same cycle after reset: a0=5, b0=3; a1=1, b1=7 -> requester 0 served first, out=15; then requester 1, out=7; in the fixed-priority build requester 0 still wins a repeated tie.
REQ-034 a1=51, b1=11 with out_ready[1] held low 5 cycles -> out=561 and out_valid[1] stay stable; busy=1; req[0] gets no ack until the handshake completes.
REQ-035 a0=63, b0=63 -> out=3969; a0=0, b0=45 -> out=0 after the same latency.
REQ-036 rst_n pulsed low in the 3rd RUN cycle -> all outputs 0 immediately; no out_valid afterwards; a new request is granted normally.
REQ-037 req[1] dropped during an active requester-0 operation -> no ack[1] is ever issued.
